fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning width of the program counter and instruction-memory address.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port RUN  input  1  free-run enable; 0 parks the unit in IDLE between instructions.
REQ-005 SHALL have port STEP  input  1  single-step request, sampled only in IDLE with RUN=0.
REQ-006 SHALL have port IMEM_ADDR  output  PC_W  synchronous instruction-ROM address.
REQ-007 SHALL have port IMEM_DATA  input  16  ROM read data, valid one cycle after the address is presented.
REQ-008 SHALL have port INST  output  16  instruction register contents, feeding the decoder.
REQ-009 SHALL have port INST_VALID  output  1  high only in EXEC; gates register-file and data-RAM writes.
REQ-010 SHALL have port HALT  input  1  halt indication from the decoder for the current INST.
REQ-011 SHALL have port ZERO  input  1  ALU result == 0 for the current INST.
REQ-012 SHALL have port NEG  input  1  ALU result bit 15 for the current INST.
REQ-013 SHALL have port PC  output  PC_W  address of the instruction held in INST.
REQ-014 SHALL have port HALTED  output  1  high while in HALTED state.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, EXEC, HALTED, one state per cycle except IDLE/HALTED.
REQ-016 IDLE SHALL go to FETCH when RUN=1, or when RUN=0 and STEP=1; otherwise stay in IDLE.
REQ-017 FETCH SHALL drive IMEM_ADDR=PC and go to LOAD unconditionally.
REQ-018 LOAD SHALL capture IMEM_DATA into INST at its closing edge and go to EXEC.
REQ-019 IMEM_ADDR SHALL equal PC in every state.
REQ-020 EXEC SHALL assert INST_VALID for exactly one cycle; INST and PC SHALL be stable throughout EXEC.
REQ-021 At the EXEC closing edge, HALT=1 SHALL take priority: go to HALTED, PC unchanged.
REQ-022 Otherwise, branch taken SHALL be: INST[15:12]=1000 and ZERO; 1001 and !ZERO; 1010 and !NEG; 1011 and NEG.
REQ-023 Taken target SHALL be PC+1+sign-extended INST[5:0], modulo 2^PC_W.
REQ-024 Not taken, including every non-branch opcode, SHALL give PC+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-025 After EXEC the next state SHALL be FETCH if RUN=1, else IDLE.
REQ-026 A STEP executes exactly one instruction; STEP held high re-triggers only on the next IDLE visit.
REQ-027 HALTED SHALL be left only by reset; RUN, STEP and HALT SHALL be ignored there, with INST held and INST_VALID=0.
REQ-028 RUN deasserted mid-instruction SHALL not abort it; it completes through EXEC first.
REQ-029 ZERO, NEG and HALT SHALL be sampled only in EXEC.

Reset
REQ-030 RST_N low SHALL immediately force state IDLE, PC=0, IMEM_ADDR=0, INST=16'h0000, INST_VALID=0, HALTED=0.
REQ-031 Reset asserted in any state, including mid-EXEC, SHALL suppress the pending PC update and INST_VALID.
REQ-032 Reset deassertion SHALL take effect at the next rising CLK; the first FETCH follows at the earliest one cycle later, with RUN=1.

Verification
REQ-033 Reset, RUN=1, ROM[0..2]=16'h5041,16'h5042,16'h0000 -> INST_VALID high every third cycle; PC 0,1,2; INST matches ROM.
REQ-034 PC=5, INST=16'h81FD (BEQ, IMM=-3), ZERO=1 -> next PC=3; same with ZERO=0 -> PC=6.
REQ-035 PC=8'hFF, non-branch, HALT=0 -> PC wraps to 0; BGEZ at PC=8'hFE with IMM=+2, NEG=0 -> PC=1.
REQ-036 HALT=1 in EXEC at PC=4 -> HALTED=1, PC stays 4, INST_VALID stays 0 despite RUN/STEP toggling; RST_N pulse -> PC=0.
REQ-037 RUN=0, one STEP pulse -> exactly one INST_VALID pulse, PC+1, return to IDLE; STEP held 10 cycles -> two instructions executed (IDLE revisited twice).
REQ-038 RST_N asserted asynchronously mid-EXEC (between edges) -> INST_VALID drops immediately, PC=0, no branch/increment applied.

Source files
------------

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch/sequencer: IDLE -> FETCH -> LOAD -> EXEC, with
// conditional relative branches, single-step support and a reset-only HALTED state.
module fetch_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     inst,
    output logic            inst_valid,
    input  logic            halt,
    input  logic            zero,
    input  logic            neg,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t          state;
    logic            taken;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_target;
    logic [PC_W-1:0] imm_ext;

    // The ROM is addressed straight from PC so the read lines up with FETCH.
    assign imem_addr = pc;

    assign imm_ext   = {{(PC_W-6){inst[5]}}, inst[5:0]};
    assign pc_seq    = pc + PC_W'(1);
    assign pc_target = pc_seq + imm_ext;

    always_comb begin
        taken = 1'b0;
        case (inst[15:12])
            4'b1000: taken = zero;
            4'b1001: taken = !zero;
            4'b1010: taken = !neg;
            4'b1011: taken = neg;
            default: taken = 1'b0;
        endcase
    end

    // inst_valid and halted are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst       <= 16'h0000;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    inst       <= imem_data;
                    inst_valid <= 1'b1;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    inst_valid <= 1'b0;
                    if (halt) begin
                        halted <= 1'b1;
                        state  <= S_HALTED;
                    end else begin
                        pc    <= taken ? pc_target : pc_seq;
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
